controle_municao: RTL and testbench
===================================

# controle_municao

Ammunition and reload sequencer for the turret. It counts remaining shots, issues one-cycle fire pulses to the trigger datapath with an enforced cooldown, and drives the `recarregar` input of `servo_recarga`, waiting for its `fim_recarga` before restoring the magazine. It sits between the turret top-level FSM (fire and reload requests) and the reload servo.

## Interface
- `CAPACIDADE`, 6: shots per full magazine (≥1).
- `INTERVALO_DISPARO`, 25_000_000: cooldown after each shot, in clock cycles (0.5 s at 50 MHz).
- `LARGURA_RECARREGAR`, 5: cycles `recarregar` is held high per reload request.
- `TIMEOUT_RECARGA`, 150_000_000: maximum cycles to wait for `fim_recarga` (3 s).
- `clock` in 1: 50 MHz system clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `atirar` in 1: fire request, level; its rising edge is the event.
- `recarregar_manual` in 1: manual reload request, level; its rising edge is the event.
- `fim_recarga` in 1: from `servo_recarga`; its rising edge is the event.
- `disparo` out 1: one-cycle pulse per accepted shot.
- `recarregar` out 1: to `servo_recarga.recarregar`.
- `municao` out $clog2(CAPACIDADE+1): remaining shots.
- `pronto` out 1: high only in PRONTO.
- `vazio` out 1: `municao == 0`.
- `erro` out 1: reload timeout flag.
- `db_estado` out 3: state encoding, for debug.

## Operation
- Input edge detection:
  - Each of `atirar`, `recarregar_manual` and `fim_recarga` has a one-stage registered edge detector.
  - Detector registers reset to 0. A level already high at reset release therefore produces an edge in the first cycle.
- States and encodings:
  - PRONTO (0): idle.
  - DISPARO (1): shot cycle.
  - ESPERA (2): cooldown.
  - PEDE_RECARGA (3): holding `recarregar` high.
  - AGUARDA_RECARGA (4): waiting for `fim_recarga`.
  - ERRO (7): reload timed out.
- PRONTO:
  - Manual edge with `municao < CAPACIDADE` → PEDE_RECARGA. Manual edge with a full magazine is ignored.
  - Otherwise, fire edge with `municao > 0` → DISPARO.
  - Manual reload has priority when both edges occur in the same cycle. The fire edge is then discarded.
  - Fire edge with `municao == 0` is ignored.
- DISPARO (1 cycle): `disparo = 1`, `municao` decrements, → ESPERA.
- ESPERA:
  - Counts `INTERVALO_DISPARO` cycles. All edges are ignored.
  - At expiry: → PEDE_RECARGA if `municao == 0` (auto-reload), else → PRONTO.
- PEDE_RECARGA: `recarregar = 1` for exactly `LARGURA_RECARREGAR` cycles, then → AGUARDA_RECARGA.
- AGUARDA_RECARGA:
  - Timeout counter starts at 0 on entry.
  - On a `fim_recarga` edge: `municao ← CAPACIDADE`, → PRONTO.
  - If the counter reaches `TIMEOUT_RECARGA` first: → ERRO.
  - A `fim_recarga` edge arriving in PEDE_RECARGA is ignored. It is stale and comes from the previous reload.
- ERRO:
  - `erro = 1`, `municao` is unchanged, fire edges are ignored.
  - A manual edge clears `erro` and → PEDE_RECARGA.
- Counters:
  - A single down-counter is shared by ESPERA, PEDE_RECARGA and AGUARDA_RECARGA.
  - Width is `$clog2` of the largest parameter.
  - It is reloaded on every state entry, so no count wraps.
- Arithmetic:
  - `municao` never underflows, because DISPARO is unreachable when it is 0.
  - It never exceeds `CAPACIDADE`.

## Timing
- Reset values:
  - State PRONTO, `municao = CAPACIDADE`, `pronto = 1`.
  - `disparo`, `recarregar`, `vazio`, `erro` are all 0.
  - `db_estado = 0`.
- Assertion of `reset` mid-operation:
  - Takes effect immediately.
  - Drops `recarregar` or `disparo` in the same instant.
  - Restores all reset values, including a full magazine.
- Latency:
  - The `atirar` rising edge sampled on clock k gives `disparo` high during cycle k+1 and `municao` decremented at k+2.
  - Fire-to-fire minimum is `INTERVALO_DISPARO + 2` cycles.
- Reload: `recarregar` rises one cycle after the triggering edge and stays high exactly `LARGURA_RECARREGAR` cycles.
- `municao = CAPACIDADE` and `pronto = 1` appear one cycle after the registered `fim_recarga` edge.
- Outputs are registered or decoded from the registered state only. No input reaches an output combinationally.

## Test plan
All scenarios use `CAPACIDADE=3`, `INTERVALO_DISPARO=10`, `LARGURA_RECARREGAR=5`, `TIMEOUT_RECARGA=200`.

- **Reset:** hold `reset=0` for 5 cycles, then release → `municao=3`, `pronto=1`, `vazio=0`, `recarregar=0`, `erro=0`.
- **Single shot:** one `atirar` pulse → exactly one `disparo` pulse, `municao=2`. A second pulse 5 cycles later produces no `disparo`. A pulse 12 or more cycles after the first produces `disparo` and `municao=1`.
- **Auto-reload:**
  - Fire 3 spaced shots → `municao=0`, `vazio=1`, then `recarregar` high exactly 5 cycles.
  - Drive a `fim_recarga` pulse 50 cycles later → `municao=3`, `pronto=1`.
- **Manual reload and priority:**
  - At `municao=2`, raise `atirar` and `recarregar_manual` in the same cycle → no `disparo`, `recarregar` asserted.
  - At `municao=3`, a manual edge is ignored.
- **Timeout:**
  - Withhold `fim_recarga` → `erro=1`, `db_estado=7` after 200 cycles in AGUARDA_RECARGA.
  - A manual edge then clears `erro` and repeats the 5-cycle `recarregar`.
- **Reset mid-reload:** assert `reset` while `recarregar=1` → `recarregar=0` immediately, `municao=3` after release.

Source files
------------

// File: rtl/controle_municao.sv
// Ammunition counter and reload sequencer for the turret: paces shots with a
// cooldown, drives servo_recarga and waits (bounded) for it to finish.
module controle_municao #(
    parameter int CAPACIDADE         = 6,
    parameter int INTERVALO_DISPARO  = 25_000_000,
    parameter int LARGURA_RECARREGAR = 5,
    parameter int TIMEOUT_RECARGA    = 150_000_000
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              atirar,
    input  logic                              recarregar_manual,
    input  logic                              fim_recarga,
    output logic                              disparo,
    output logic                              recarregar,
    output logic [$clog2(CAPACIDADE+1)-1:0]   municao,
    output logic                              pronto,
    output logic                              vazio,
    output logic                              erro,
    output logic [2:0]                        db_estado
);

    localparam int MW    = $clog2(CAPACIDADE + 1);
    localparam int MAX_A = (INTERVALO_DISPARO > LARGURA_RECARREGAR) ? INTERVALO_DISPARO
                                                                     : LARGURA_RECARREGAR;
    localparam int MAXP  = (MAX_A > TIMEOUT_RECARGA) ? MAX_A : TIMEOUT_RECARGA;
    localparam int CW    = (MAXP > 1) ? $clog2(MAXP) : 1;

    localparam logic [MW-1:0] CHEIO    = MW'(CAPACIDADE);
    localparam logic [CW-1:0] CARGA_IN = CW'(INTERVALO_DISPARO - 1);
    localparam logic [CW-1:0] CARGA_LR = CW'(LARGURA_RECARREGAR - 1);
    localparam logic [CW-1:0] CARGA_TO = CW'(TIMEOUT_RECARGA - 1);

    typedef enum logic [2:0] {
        PRONTO          = 3'd0,
        DISPARO         = 3'd1,
        ESPERA          = 3'd2,
        PEDE_RECARGA    = 3'd3,
        AGUARDA_RECARGA = 3'd4,
        ERRO            = 3'd7
    } estado_t;

    estado_t         estado, prox_estado;
    logic [CW-1:0]   cnt, prox_cnt;
    logic [MW-1:0]   prox_municao;
    logic            atirar_q, manual_q, fim_q;
    logic            borda_tiro, borda_manual, borda_fim;

    // Detector registers clear to 0, so a level held high through reset
    // release is seen as an edge on the first clock.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            atirar_q <= 1'b0;
            manual_q <= 1'b0;
            fim_q    <= 1'b0;
        end else begin
            atirar_q <= atirar;
            manual_q <= recarregar_manual;
            fim_q    <= fim_recarga;
        end
    end

    assign borda_tiro   = atirar & ~atirar_q;
    assign borda_manual = recarregar_manual & ~manual_q;
    assign borda_fim    = fim_recarga & ~fim_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado  <= PRONTO;
            cnt     <= '0;
            municao <= CHEIO;
        end else begin
            estado  <= prox_estado;
            cnt     <= prox_cnt;
            municao <= prox_municao;
        end
    end

    // One shared down-counter, reloaded on each entry to a timed state and
    // leaving that state when it reads zero.
    always_comb begin
        prox_estado  = estado;
        prox_cnt     = cnt;
        prox_municao = municao;
        case (estado)
            PRONTO: begin
                if (borda_manual && municao < CHEIO) begin
                    prox_estado = PEDE_RECARGA;
                    prox_cnt    = CARGA_LR;
                end else if (borda_tiro && municao != '0) begin
                    prox_estado = DISPARO;
                end
            end
            DISPARO: begin
                prox_municao = municao - 1'b1;
                prox_estado  = ESPERA;
                prox_cnt     = CARGA_IN;
            end
            ESPERA: begin
                if (cnt == '0) begin
                    if (municao == '0) begin
                        prox_estado = PEDE_RECARGA;
                        prox_cnt    = CARGA_LR;
                    end else begin
                        prox_estado = PRONTO;
                    end
                end else begin
                    prox_cnt = cnt - 1'b1;
                end
            end
            PEDE_RECARGA: begin
                // fim_recarga edges here belong to the previous reload
                if (cnt == '0) begin
                    prox_estado = AGUARDA_RECARGA;
                    prox_cnt    = CARGA_TO;
                end else begin
                    prox_cnt = cnt - 1'b1;
                end
            end
            AGUARDA_RECARGA: begin
                if (borda_fim) begin
                    prox_municao = CHEIO;
                    prox_estado  = PRONTO;
                end else if (cnt == '0) begin
                    prox_estado = ERRO;
                end else begin
                    prox_cnt = cnt - 1'b1;
                end
            end
            ERRO: begin
                if (borda_manual) begin
                    prox_estado = PEDE_RECARGA;
                    prox_cnt    = CARGA_LR;
                end
            end
            default: prox_estado = PRONTO;
        endcase
    end

    assign disparo    = (estado == DISPARO);
    assign recarregar = (estado == PEDE_RECARGA);
    assign pronto     = (estado == PRONTO);
    assign erro       = (estado == ERRO);
    assign vazio      = (municao == '0);
    assign db_estado  = estado;

endmodule

// File: tb/tb_controle_municao.sv
// Directed bench for controle_municao with a small magazine and short timers.
module tb_controle_municao;

    localparam int CAP = 3;
    localparam int INT = 10;
    localparam int LAR = 5;
    localparam int TO  = 200;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       atirar = 1'b0, recarregar_manual = 1'b0, fim_recarga = 1'b0;
    logic       disparo, recarregar, pronto, vazio, erro;
    logic [1:0] municao;
    logic [2:0] db_estado;

    int n_chk = 0;
    int n_err = 0;
    int ndisp = 0;

    controle_municao #(
        .CAPACIDADE(CAP), .INTERVALO_DISPARO(INT),
        .LARGURA_RECARREGAR(LAR), .TIMEOUT_RECARGA(TO)
    ) dut (
        .clock(clock), .reset(reset), .atirar(atirar),
        .recarregar_manual(recarregar_manual), .fim_recarga(fim_recarga),
        .disparo(disparo), .recarregar(recarregar), .municao(municao),
        .pronto(pronto), .vazio(vazio), .erro(erro), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (disparo) ndisp <= ndisp + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic fire_pulse();
        atirar = 1'b1;
        tick();
        atirar = 1'b0;
    endtask

    task automatic manual_pulse();
        recarregar_manual = 1'b1;
        tick();
        recarregar_manual = 1'b0;
    endtask

    task automatic wait_pronto(input string tag);
        int n = 0;
        while (!pronto && n < 40) begin
            tick();
            n++;
        end
        chk(tag, int'(pronto), 1);
    endtask

    // Waits (bounded) for recarregar, then counts its high cycles.
    task automatic measure_rec(input string tag);
        int n = 0;
        int w = 0;
        while (!recarregar && w < 40) begin
            tick();
            w++;
        end
        while (recarregar && n < 20) begin
            tick();
            n++;
        end
        chk(tag, n, LAR);
    endtask

    initial begin
        // Reset
        tick(5);
        chk("rst_hold_municao", int'(municao), 3);
        reset = 1'b1;
        tick();
        chk("rst_municao", int'(municao), 3);
        chk("rst_pronto", int'(pronto), 1);
        chk("rst_vazio", int'(vazio), 0);
        chk("rst_recarregar", int'(recarregar), 0);
        chk("rst_erro", int'(erro), 0);
        chk("rst_disparo", int'(disparo), 0);
        chk("rst_estado", int'(db_estado), 0);

        // Single shot, blocked shot during cooldown, shot at INT+2
        fire_pulse();
        chk("s1_disparo", int'(disparo), 1);
        chk("s1_municao_pre", int'(municao), 3);
        tick();
        chk("s1_disparo_off", int'(disparo), 0);
        chk("s1_municao", int'(municao), 2);
        tick(3);
        fire_pulse();
        chk("cooldown_no_shot", int'(disparo), 0);
        chk("cooldown_estado", int'(db_estado), 2);
        tick(5);
        chk("cooldown_last", int'(db_estado), 2);
        tick();
        chk("cooldown_end_pronto", int'(pronto), 1);
        fire_pulse();
        chk("s2_disparo", int'(disparo), 1);
        tick();
        chk("s2_municao", int'(municao), 1);
        chk("shot_count_2", ndisp, 2);

        // Third shot empties the magazine and triggers auto-reload
        wait_pronto("s3_wait");
        fire_pulse();
        chk("s3_disparo", int'(disparo), 1);
        tick();
        chk("s3_municao", int'(municao), 0);
        chk("s3_vazio", int'(vazio), 1);
        fire_pulse();
        chk("empty_no_shot", int'(disparo), 0);
        measure_rec("auto_rec_width");
        chk("aguarda_estado", int'(db_estado), 4);
        tick(50);
        fim_recarga = 1'b1;
        tick();
        fim_recarga = 1'b0;
        chk("auto_municao", int'(municao), 3);
        chk("auto_pronto", int'(pronto), 1);
        chk("auto_vazio", int'(vazio), 0);
        chk("shot_count_3", ndisp, 3);

        // Manual reload ignored when full
        manual_pulse();
        chk("full_manual_estado", int'(db_estado), 0);
        tick();
        chk("full_manual_rec", int'(recarregar), 0);

        // Manual reload wins over a simultaneous fire edge
        fire_pulse();
        wait_pronto("prio_wait");
        chk("prio_municao", int'(municao), 2);
        atirar = 1'b1;
        recarregar_manual = 1'b1;
        tick();
        atirar = 1'b0;
        recarregar_manual = 1'b0;
        chk("prio_disparo", int'(disparo), 0);
        chk("prio_recarregar", int'(recarregar), 1);
        chk("prio_estado", int'(db_estado), 3);
        measure_rec("prio_rec_width");
        chk("prio_shot_count", ndisp, 4);

        // Timeout: fim_recarga withheld
        tick(TO - 1);
        chk("to_before_estado", int'(db_estado), 4);
        chk("to_before_erro", int'(erro), 0);
        tick();
        chk("to_estado", int'(db_estado), 7);
        chk("to_erro", int'(erro), 1);
        fire_pulse();
        chk("erro_no_shot", int'(disparo), 0);
        chk("erro_municao", int'(municao), 2);
        manual_pulse();
        chk("erro_cleared", int'(erro), 0);
        chk("erro_rec", int'(recarregar), 1);
        measure_rec("erro_rec_width");
        fim_recarga = 1'b1;
        tick();
        fim_recarga = 1'b0;
        chk("erro_reload_municao", int'(municao), 3);

        // Reset while recarregar is high
        fire_pulse();
        wait_pronto("mid_wait");
        manual_pulse();
        chk("mid_rec_on", int'(recarregar), 1);
        tick(2);
        reset = 1'b0;
        #1;
        chk("mid_rec_off", int'(recarregar), 0);
        chk("mid_estado", int'(db_estado), 0);
        tick(2);
        reset = 1'b1;
        tick();
        chk("mid_municao", int'(municao), 3);
        chk("mid_pronto", int'(pronto), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
